// File: rtl/spmv_pkg.sv
// Shared types and default widths for the sparse matrix-vector row accumulator.
package spmv_pkg;
    localparam int SPMV_DATA_W = 16;
    localparam int SPMV_ACC_W  = 40;
    localparam int SPMV_LEN_W  = 5;
    localparam int ROW_IDX_MAX = 31;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } state_t;
endpackage

// File: rtl/spmv_mac.sv
// Combinational signed multiply, sign-extend and add; zero latency, no flow control.
module spmv_mac #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 40
) (
    input  logic [DATA_W-1:0] mat_val,
    input  logic [DATA_W-1:0] vec_val,
    input  logic [ACC_W-1:0]  acc_in,
    output logic [ACC_W-1:0]  sum
);
    logic signed [2*DATA_W-1:0] prod;

    assign prod = $signed(mat_val) * $signed(vec_val);
    // Accumulator wraps modulo 2^ACC_W; no saturation.
    assign sum  = acc_in + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
endmodule

// File: rtl/spmv_row_accumulator.sv
// Per-row dot-product accumulator: result valid 1 cycle after the last element accept,
// holds res_valid/res_sum/res_row stable under res_ready backpressure and accepts nothing while emitting.
module spmv_row_accumulator
    import spmv_pkg::*;
#(
    parameter int DATA_W = SPMV_DATA_W,
    parameter int ACC_W  = SPMV_ACC_W,
    parameter int LEN_W  = SPMV_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              len_valid,
    output logic              len_ready,
    input  logic [LEN_W-1:0]  row_len,
    input  logic              elem_valid,
    output logic              elem_ready,
    input  logic [DATA_W-1:0] mat_val,
    input  logic [DATA_W-1:0] vec_val,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [ACC_W-1:0]  res_sum,
    output logic [LEN_W-1:0]  res_row,
    output logic              busy
);
    state_t             state;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   mac_sum;
    logic [LEN_W-1:0]   remaining;
    logic [LEN_W-1:0]   row_idx;

    spmv_mac #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .mat_val (mat_val),
        .vec_val (vec_val),
        .acc_in  (acc),
        .sum     (mac_sum)
    );

    assign busy = (state != IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            acc        <= '0;
            remaining  <= '0;
            row_idx    <= '0;
            res_valid  <= 1'b0;
            res_sum    <= '0;
            res_row    <= '0;
            len_ready  <= 1'b0;
            elem_ready <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    len_ready  <= 1'b1;
                    elem_ready <= 1'b0;
                    if (len_valid && len_ready) begin
                        len_ready <= 1'b0;
                        if (row_len == '0) begin
                            // Empty rows still produce a zero result for the writer.
                            res_sum   <= '0;
                            res_row   <= row_idx;
                            res_valid <= 1'b1;
                            state     <= EMIT;
                        end else begin
                            remaining  <= row_len;
                            acc        <= '0;
                            elem_ready <= 1'b1;
                            state      <= ACCUM;
                        end
                    end
                end
                ACCUM: begin
                    if (elem_valid && elem_ready) begin
                        acc       <= mac_sum;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            res_sum    <= mac_sum;
                            res_row    <= row_idx;
                            res_valid  <= 1'b1;
                            elem_ready <= 1'b0;
                            state      <= EMIT;
                        end
                    end
                end
                EMIT: begin
                    if (res_valid && res_ready) begin
                        res_valid <= 1'b0;
                        row_idx   <= (row_idx == LEN_W'(ROW_IDX_MAX)) ? '0 : row_idx + LEN_W'(1);
                        len_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state      <= IDLE;
                    len_ready  <= 1'b0;
                    elem_ready <= 1'b0;
                    res_valid  <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_spmv_row_accumulator.sv
// Directed and randomized bench for spmv_row_accumulator with a row-level arithmetic reference model.
module tb_spmv_row_accumulator;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        len_valid;
    logic        len_ready;
    logic [4:0]  row_len;
    logic        elem_valid;
    logic        elem_ready;
    logic [15:0] mat_val;
    logic [15:0] vec_val;
    logic        res_valid;
    logic        res_ready;
    logic [39:0] res_sum;
    logic [4:0]  res_row;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int elem_cnt = 0;
    int row_model = 0;
    int mv [32];
    int vv [32];

    spmv_row_accumulator dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .len_valid  (len_valid),
        .len_ready  (len_ready),
        .row_len    (row_len),
        .elem_valid (elem_valid),
        .elem_ready (elem_ready),
        .mat_val    (mat_val),
        .vec_val    (vec_val),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_sum    (res_sum),
        .res_row    (res_row),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Inputs only change 1 time unit after a rising edge, so at the falling edge
    // valid & ready show exactly what the next rising edge will transfer.
    always @(negedge clk) begin
        if (reset_n && elem_valid && elem_ready)
            elem_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_res_valid"}, 64'(res_valid), 64'd0);
        check({tag, "_res_sum"}, 64'(res_sum), 64'd0);
        check({tag, "_res_row"}, 64'(res_row), 64'd0);
        check({tag, "_len_ready"}, 64'(len_ready), 64'd0);
        check({tag, "_elem_ready"}, 64'(elem_ready), 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    task automatic send_len(input int len);
        int n = 0;
        row_len   = 5'(len);
        len_valid = 1'b1;
        while (!len_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("len_wait", 64'(n < 50), 64'd1);
        @(posedge clk); #1;
        len_valid = 1'b0;
    endtask

    task automatic send_elem(input int m, input int v);
        int n = 0;
        elem_valid = 1'b1;
        mat_val    = 16'(m);
        vec_val    = 16'(v);
        while (!elem_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("elem_wait", 64'(n < 50), 64'd1);
        check("res_early", 64'(res_valid), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic send_row(input int len, input bit bubbles, input int hold);
        longint      acc = 0;
        logic [39:0] exp;
        int          c0;
        for (int i = 0; i < len; i++)
            acc += longint'(mv[i] * vv[i]);
        exp = acc[39:0];
        c0 = elem_cnt;
        res_ready = (hold == 0);
        send_len(len);
        for (int i = 0; i < len; i++) begin
            if (bubbles && i > 0) begin
                elem_valid = 1'b0;
                @(posedge clk); #1;
            end
            send_elem(mv[i], vv[i]);
        end
        if (len > 0)
            elem_valid = 1'b0;
        check("res_latency", 64'(res_valid), 64'd1);
        check("busy_emit", 64'(busy), 64'd1);
        for (int h = 0; h < hold; h++) begin
            check("hold_valid", 64'(res_valid), 64'd1);
            check("hold_sum", 64'(res_sum), 64'(exp));
            check("hold_row", 64'(res_row), 64'(row_model));
            check("hold_len_ready", 64'(len_ready), 64'd0);
            check("hold_elem_ready", 64'(elem_ready), 64'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        check("res_sum", 64'(res_sum), 64'(exp));
        check("res_row", 64'(res_row), 64'(row_model));
        @(posedge clk); #1;
        check("res_accepted", 64'(res_valid), 64'd0);
        check("elem_consumed", 64'(elem_cnt - c0), 64'(len));
        row_model = (row_model + 1) % 32;
    endtask

    function automatic int rnd16();
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        reset_n    = 1'b0;
        len_valid  = 1'b0;
        row_len    = '0;
        elem_valid = 1'b0;
        mat_val    = '0;
        vec_val    = '0;
        res_ready  = 1'b0;
        #12;
        check_all_zero("reset");
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("len_ready_idle", 64'(len_ready), 64'd1);

        // Basic row: 6 - 20 - 7
        mv[0] = 2;  vv[0] = 3;
        mv[1] = -4; vv[1] = 5;
        mv[2] = 7;  vv[2] = -1;
        send_row(3, 1'b0, 0);

        // Empty row with elem_valid held high throughout
        elem_valid = 1'b1;
        mat_val = 16'd9;
        vec_val = 16'd9;
        send_row(0, 1'b0, 0);
        elem_valid = 1'b0;

        // Backpressure on the result
        mv[0] = 1; vv[0] = 1;
        mv[1] = 1; vv[1] = 1;
        send_row(2, 1'b0, 5);

        // Extreme operands: 31 * 2^30
        for (int i = 0; i < 31; i++) begin
            mv[i] = -32768;
            vv[i] = -32768;
        end
        send_row(31, 1'b0, 0);

        // Bubbles between elements
        mv[0] = 1; vv[0] = 2;
        mv[1] = 3; vv[1] = 4;
        mv[2] = 5; vv[2] = 6;
        mv[3] = 7; vv[3] = 8;
        send_row(4, 1'b1, 0);

        // Randomized rows
        for (int r = 0; r < 12; r++) begin
            int len;
            len = int'($urandom_range(0, 31));
            for (int i = 0; i < len; i++) begin
                mv[i] = rnd16();
                vv[i] = rnd16();
            end
            send_row(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 3)));
        end

        // Reset in the middle of a 4-element row
        send_len(4);
        send_elem(3, 3);
        send_elem(4, 4);
        elem_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        @(negedge clk);
        reset_n = 1'b1;
        row_model = 0;
        @(posedge clk); #1;
        mv[0] = 5; vv[0] = 5;
        send_row(1, 1'b0, 0);

        // 32 more rows so the row index runs 1..31 and wraps to 0
        for (int r = 0; r < 32; r++) begin
            int len;
            len = int'($urandom_range(0, 2));
            for (int i = 0; i < len; i++) begin
                mv[i] = rnd16();
                vv[i] = rnd16();
            end
            send_row(len, 1'b0, 0);
        end
        check("row_wrapped", 64'(row_model), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
